// File: rtl/alu_mult_sequencer_pkg.sv
// Shared definitions for the shift-add multiply sequencer: ALU op codes,
// default datapath width and the controller state type.
package alu_mult_sequencer_pkg;

  localparam int unsigned WIDTH_DEF = 32;

  // Op codes shared with ALU_Control; only ADD is issued by the sequencer.
  localparam logic [3:0] ALU_OP_NOP = 4'b0000;
  localparam logic [3:0] ALU_OP_ADD = 4'b0011;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } seq_state_t;

endpackage

// File: rtl/alu_mult_sequencer_if.sv
// Bundle between the core/ALU mux and the multiply sequencer.
// master = core side (start, operands, ALU result); slave = sequencer.
interface alu_mult_sequencer_if
  import alu_mult_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
);
  logic             start_i;
  logic [WIDTH-1:0] multiplicand_i;
  logic [WIDTH-1:0] multiplier_i;
  logic [WIDTH-1:0] alu_result_i;
  logic             alu_sel_o;
  logic [3:0]       alu_operation_o;
  logic [WIDTH-1:0] alu_a_o;
  logic [WIDTH-1:0] alu_b_o;
  logic             busy_o;
  logic             done_o;
  logic [WIDTH-1:0] product_o;

  modport master (
    output start_i, multiplicand_i, multiplier_i, alu_result_i,
    input  alu_sel_o, alu_operation_o, alu_a_o, alu_b_o, busy_o, done_o, product_o
  );

  modport slave (
    input  start_i, multiplicand_i, multiplier_i, alu_result_i,
    output alu_sel_o, alu_operation_o, alu_a_o, alu_b_o, busy_o, done_o, product_o
  );
endinterface

// File: rtl/alu_mult_sequencer.sv
// Multi-cycle MULT-low controller: shift-add using the shared datapath ALU,
// one ADD per RUN cycle, early exit once the remaining multiplier bits are zero.
module alu_mult_sequencer
  import alu_mult_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH   = WIDTH_DEF,
  parameter int unsigned CNT_W   = 6,
  parameter logic [3:0]  ALU_ADD = ALU_OP_ADD
) (
  input  logic                 clk,
  input  logic                 reset,
  alu_mult_sequencer_if.slave  bus
);

  seq_state_t       state;
  seq_state_t       state_next;
  logic [WIDTH-1:0] acc_r;
  logic [WIDTH-1:0] mcand_r;
  logic [WIDTH-1:0] mplier_r;
  logic [WIDTH-1:0] product_r;
  logic [CNT_W-1:0] cnt_r;
  logic             operands_nonzero;
  logic             run_last;

  assign operands_nonzero = (bus.multiplicand_i != '0) && (bus.multiplier_i != '0);
  assign run_last         = ((mplier_r >> 1) == '0) || (cnt_r == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (bus.start_i) state_next = operands_nonzero ? RUN : DONE;
      RUN:  if (run_last)    state_next = DONE;
      DONE:                  state_next = IDLE;
      default:               state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.alu_sel_o       = 1'b0;
    bus.alu_operation_o = ALU_OP_NOP;
    bus.alu_a_o         = '0;
    bus.alu_b_o         = '0;
    bus.busy_o          = 1'b0;
    bus.done_o          = 1'b0;
    unique case (state)
      RUN: begin
        bus.alu_sel_o       = 1'b1;
        bus.alu_operation_o = ALU_ADD;
        bus.alu_a_o         = acc_r;
        bus.alu_b_o         = mplier_r[0] ? mcand_r : '0;
        bus.busy_o          = 1'b1;
      end
      DONE: begin
        bus.busy_o = 1'b1;
        bus.done_o = 1'b1;
      end
      default: ;
    endcase
  end

  // product_r is loaded on the edge into DONE (final ALU sum, or 0 on the
  // zero fast path) so it is already valid while done_o is high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_r     <= '0;
      mcand_r   <= '0;
      mplier_r  <= '0;
      cnt_r     <= '0;
      product_r <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start_i) begin
            mcand_r  <= bus.multiplicand_i;
            mplier_r <= bus.multiplier_i;
            acc_r    <= '0;
            cnt_r    <= '0;
            if (!operands_nonzero) product_r <= '0;
          end
        end
        RUN: begin
          acc_r    <= bus.alu_result_i;
          mcand_r  <= mcand_r << 1;
          mplier_r <= mplier_r >> 1;
          cnt_r    <= cnt_r + 1'b1;
          if (run_last) product_r <= bus.alu_result_i;
        end
        default: ;
      endcase
    end
  end

  assign bus.product_o = product_r;

endmodule
